// File: rtl/key_decoder.sv
// PS/2 scancode stream to held-key vector for the game controls.
// Tracks make/break/E0 prefixes, OR-merges plain and extended keys per bit, and abandons stalled prefixes.
module key_decoder #(
  parameter int PREFIX_TIMEOUT = 650000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] key,
  output logic [3:0] key_press,
  output logic       seq_err,
  output logic [1:0] state_dbg
);

  // Handshake: rx_valid is a one-cycle strobe, one strobe per byte; there is no back-pressure.
  // state_dbg encoding: 0=IDLE, 1=EXT, 2=BRK, 3=EXT_BRK.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_nxt;
  logic [3:0]       plain, plain_nxt;
  logic [3:0]       ext, ext_nxt;
  logic [3:0]       plain_hit, ext_hit;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic [3:0]       key_nxt;

  always_comb begin
    plain_hit = 4'b0000;
    case (rx_data)
      8'h1C:   plain_hit = 4'b0001;
      8'h23:   plain_hit = 4'b0010;
      8'h1D:   plain_hit = 4'b0100;
      8'h29:   plain_hit = 4'b1000;
      default: plain_hit = 4'b0000;
    endcase
  end

  always_comb begin
    ext_hit = 4'b0000;
    case (rx_data)
      8'h6B:   ext_hit = 4'b0001;
      8'h74:   ext_hit = 4'b0010;
      8'h75:   ext_hit = 4'b0100;
      8'h5A:   ext_hit = 4'b1000;
      default: ext_hit = 4'b0000;
    endcase
  end

  // The counter defaults to zero, which covers both "clear on prefix entry" and "hold at 0 in IDLE".
  always_comb begin
    state_nxt = state;
    plain_nxt = plain;
    ext_nxt   = ext;
    cnt_nxt   = '0;
    err_nxt   = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0)      state_nxt = EXT;
          else if (rx_data == 8'hF0) state_nxt = BRK;
          else if (rx_data == 8'hAA) begin
            plain_nxt = 4'b0000;
            ext_nxt   = 4'b0000;
          end else                   plain_nxt = plain | plain_hit;
        end
        EXT: begin
          if (rx_data == 8'hF0)      state_nxt = EXT_BRK;
          else if (rx_data == 8'hE0) err_nxt = 1'b1;
          else begin
            ext_nxt   = ext | ext_hit;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          err_nxt   = (rx_data == 8'hE0) || (rx_data == 8'hF0);
          plain_nxt = plain & ~plain_hit;
          state_nxt = IDLE;
        end
        default: begin
          err_nxt   = (rx_data == 8'hE0) || (rx_data == 8'hF0);
          ext_nxt   = ext & ~ext_hit;
          state_nxt = IDLE;
        end
      endcase
    end else if (state != IDLE) begin
      if (cnt == TIMEOUT_LAST) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  assign key_nxt = plain_nxt | ext_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      plain     <= 4'b0000;
      ext       <= 4'b0000;
      cnt       <= '0;
      key       <= 4'b0000;
      key_press <= 4'b0000;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      plain     <= plain_nxt;
      ext       <= ext_nxt;
      cnt       <= cnt_nxt;
      key       <= key_nxt;
      key_press <= key_nxt & ~key;
      seq_err   <= err_nxt;
    end
  end

  assign state_dbg = state;

endmodule
